// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_RUN     = 2'd1,
      S_MEMWAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_EX = 2'd1,
      FWD_WB = 2'd2
   } fwd_sel_e;

   // A producer writes a source register that the ID instruction actually reads; x0 never counts.
   function automatic logic raw_match(input logic       valid,
                                      input logic       wen,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic       use_rs);
      return valid && wen && (rd != 5'd0) && (rd == rs) && use_rs;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// rtl/pipeline_ctrl_fwd_unit.sv - single-operand forwarding compare
module pipeline_ctrl_fwd_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic       use_rs_i,
   input  logic       ex_valid_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_reg_wen_i,
   input  logic       ex_is_load_i,
   input  logic       wb_valid_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_reg_wen_i,
   output logic [1:0] sel_o,
   output logic       ex_raw_o,
   output logic       wb_raw_o
);

   always_comb begin
      ex_raw_o = raw_match(ex_valid_i, ex_reg_wen_i, ex_rd_i, rs_i, use_rs_i);
      wb_raw_o = raw_match(wb_valid_i, wb_reg_wen_i, wb_rd_i, rs_i, use_rs_i);
      // A load in EX has no result yet, so an older WB value may still be the right source.
      if (ex_raw_o && !ex_is_load_i) begin
         sel_o = FWD_EX;
      end else if (wb_raw_o) begin
         sel_o = FWD_WB;
      end else begin
         sel_o = FWD_RF;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, stall/flush sequencing and perf counters for the 3-stage core
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH     = 32,
   parameter bit FWD_EN        = 1'b1,
   parameter int RESET_BUBBLES = 2
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [4:0]           id_rs1,
   input  logic [4:0]           id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic                 ex_valid,
   input  logic [4:0]           ex_rd,
   input  logic                 ex_reg_wen,
   input  logic                 ex_is_load,
   input  logic                 ex_redirect,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_rd,
   input  logic                 wb_reg_wen,
   output logic [1:0]           fwd_a_sel,
   output logic [1:0]           fwd_b_sel,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 flush_id,
   output logic                 bubble_ex,
   output logic                 pc_redirect_en,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic [CNT_WIDTH-1:0] instret_cnt
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;
   localparam logic [15:0]          INIT_LAST = 16'(RESET_BUBBLES - 1);

   state_e               state_q, state_d;
   logic [15:0]          init_cnt_q, init_cnt_d;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;

   logic [1:0] sel_a, sel_b;
   logic       a_ex_raw, a_wb_raw, b_ex_raw, b_wb_raw;
   logic       load_use, raw_any, hazard_stall, mem_stall, redirect, init_done;

   pipeline_ctrl_fwd_unit u_fwd_a (
      .rs_i         (id_rs1),
      .use_rs_i     (id_use_rs1),
      .ex_valid_i   (ex_valid),
      .ex_rd_i      (ex_rd),
      .ex_reg_wen_i (ex_reg_wen),
      .ex_is_load_i (ex_is_load),
      .wb_valid_i   (wb_valid),
      .wb_rd_i      (wb_rd),
      .wb_reg_wen_i (wb_reg_wen),
      .sel_o        (sel_a),
      .ex_raw_o     (a_ex_raw),
      .wb_raw_o     (a_wb_raw)
   );

   pipeline_ctrl_fwd_unit u_fwd_b (
      .rs_i         (id_rs2),
      .use_rs_i     (id_use_rs2),
      .ex_valid_i   (ex_valid),
      .ex_rd_i      (ex_rd),
      .ex_reg_wen_i (ex_reg_wen),
      .ex_is_load_i (ex_is_load),
      .wb_valid_i   (wb_valid),
      .wb_rd_i      (wb_rd),
      .wb_reg_wen_i (wb_reg_wen),
      .sel_o        (sel_b),
      .ex_raw_o     (b_ex_raw),
      .wb_raw_o     (b_wb_raw)
   );

   // Without forwarding, every RAW dependency on EX or WB must wait like a load-use.
   assign load_use     = id_valid && ex_is_load && (a_ex_raw || b_ex_raw);
   assign raw_any      = id_valid && (a_ex_raw || b_ex_raw || a_wb_raw || b_wb_raw);
   assign hazard_stall = FWD_EN ? load_use : raw_any;
   assign mem_stall    = mem_req && !mem_ready;
   assign redirect     = ex_redirect && ex_valid;
   assign init_done    = (RESET_BUBBLES <= 1) || (init_cnt_q == INIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_INIT;
         init_cnt_q <= '0;
         cycle_q    <= '0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         cycle_q    <= cycle_d;
         instret_q  <= instret_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = '0;
      cycle_d    = cycle_q + CNT_ONE;
      instret_d  = wb_valid ? (instret_q + CNT_ONE) : instret_q;
      case (state_q)
         S_INIT: begin
            init_cnt_d = init_cnt_q + 16'd1;
            if (init_done) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (mem_stall) begin
               state_d = S_MEMWAIT;
            end
         end
         S_MEMWAIT: begin
            if (mem_ready) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   always_comb begin
      stall_if       = 1'b0;
      stall_id       = 1'b0;
      flush_id       = 1'b0;
      bubble_ex      = 1'b0;
      pc_redirect_en = 1'b0;
      fwd_a_sel      = FWD_EN ? sel_a : FWD_RF;
      fwd_b_sel      = FWD_EN ? sel_b : FWD_RF;
      if (!rst) begin
         stall_if  = 1'b1;
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
         fwd_a_sel = FWD_RF;
         fwd_b_sel = FWD_RF;
      end else begin
         case (state_q)
            S_INIT: begin
               flush_id  = 1'b1;
               bubble_ex = 1'b1;
            end
            S_RUN: begin
               // Memory wait outranks redirect, which outranks the load-use stall.
               if (mem_stall) begin
                  stall_if = 1'b1;
                  stall_id = 1'b1;
               end else if (redirect) begin
                  pc_redirect_en = 1'b1;
                  flush_id       = 1'b1;
                  bubble_ex      = 1'b1;
               end else if (hazard_stall) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
               end
            end
            S_MEMWAIT: begin
               stall_if = 1'b1;
               stall_id = 1'b1;
            end
            default: begin
               flush_id  = 1'b1;
               bubble_ex = 1'b1;
            end
         endcase
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          id_valid, id_use_rs1, id_use_rs2;
   logic [4:0]    id_rs1, id_rs2, ex_rd, wb_rd;
   logic          ex_valid, ex_reg_wen, ex_is_load, ex_redirect;
   logic          mem_req, mem_ready, wb_valid, wb_reg_wen;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          stall_if, stall_id, flush_id, bubble_ex, pc_redirect_en;
   logic [CW-1:0] cycle_cnt, instret_cnt;

   int total = 0;
   int bad   = 0;

   pipeline_ctrl #(.CNT_WIDTH(CW), .FWD_EN(1'b1), .RESET_BUBBLES(2)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
      .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_wen(wb_reg_wen),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
      .bubble_ex(bubble_ex), .pc_redirect_en(pc_redirect_en),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycles left in the post-reset flush, whether a memory access is outstanding,
   // and the two counters as plain integers.
   int m_init_left = 0;
   bit m_wait      = 0;
   bit m_known     = 0;
   int m_cyc       = 0;
   int m_ret       = 0;

   function automatic int producer(input logic [4:0] r, input logic u);
      if (!u || r == 5'd0) return 0;
      if (ex_valid && ex_reg_wen && !ex_is_load && ex_rd == r) return 1;
      if (wb_valid && wb_reg_wen && wb_rd == r) return 2;
      return 0;
   endfunction

   function automatic bit id_reads(input logic [4:0] r);
      return (id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r);
   endfunction

   task automatic check_model();
      int e_fa, e_fb, e_sif, e_sid, e_fl, e_bu, e_re;
      bit lu;
      e_fa = producer(id_rs1, id_use_rs1);
      e_fb = producer(id_rs2, id_use_rs2);
      e_sif = 0; e_sid = 0; e_fl = 0; e_bu = 0; e_re = 0;
      lu = id_valid && ex_valid && ex_is_load && ex_reg_wen && ex_rd != 5'd0 && id_reads(ex_rd);
      if (!rst) begin
         e_fa = 0; e_fb = 0; e_sif = 1; e_fl = 1; e_bu = 1;
      end else if (m_init_left > 0) begin
         e_fl = 1; e_bu = 1;
      end else if (m_wait || (mem_req && !mem_ready)) begin
         e_sif = 1; e_sid = 1;
      end else if (ex_redirect && ex_valid) begin
         e_re = 1; e_fl = 1; e_bu = 1;
      end else if (lu) begin
         e_sif = 1; e_sid = 1; e_bu = 1;
      end
      check("m_fwd_a", int'(fwd_a_sel), e_fa);
      check("m_fwd_b", int'(fwd_b_sel), e_fb);
      check("m_stall_if", int'(stall_if), e_sif);
      check("m_stall_id", int'(stall_id), e_sid);
      check("m_flush_id", int'(flush_id), e_fl);
      check("m_bubble_ex", int'(bubble_ex), e_bu);
      check("m_redirect", int'(pc_redirect_en), e_re);
      if (m_known) begin
         check("m_cycle_cnt", int'(cycle_cnt), m_cyc);
         check("m_instret_cnt", int'(instret_cnt), m_ret);
      end
   endtask

   task automatic update_model();
      if (!rst) begin
         m_init_left = 2; m_wait = 0; m_cyc = 0; m_ret = 0; m_known = 1;
      end else begin
         m_cyc = (m_cyc + 1) % (1 << CW);
         if (wb_valid) m_ret = (m_ret + 1) % (1 << CW);
         if (m_init_left > 0) m_init_left--;
         else if (m_wait) m_wait = !mem_ready;
         else if (mem_req && !mem_ready) m_wait = 1;
      end
   endtask

   task automatic tick();
      #1;
      check_model();
      update_model();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_valid = 0; ex_rd = 0; ex_reg_wen = 0; ex_is_load = 0; ex_redirect = 0;
      mem_req = 0; mem_ready = 0; wb_valid = 0; wb_rd = 0; wb_reg_wen = 0;
   endtask

   typedef struct {
      int idv, rs1, rs2, u1, u2;
      int exv, exrd, exwen, exld, exredir;
      int wbv, wbrd, wbwen;
      int fa, fb, st, fl, bu, re;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{1,5,5,1,1, 1,5,1,0,0, 0,0,0, 1,1,0,0,0,0};
      vecs[1]  = '{1,5,5,1,1, 0,0,0,0,0, 1,5,1, 2,2,0,0,0,0};
      vecs[2]  = '{1,5,5,1,1, 1,5,1,0,0, 1,5,1, 1,1,0,0,0,0};
      vecs[3]  = '{1,3,7,1,1, 1,7,1,1,0, 0,0,0, 0,0,1,0,1,0};
      vecs[4]  = '{1,0,0,1,1, 1,0,1,1,0, 0,0,0, 0,0,0,0,0,0};
      vecs[5]  = '{1,3,7,1,0, 1,7,1,1,0, 0,0,0, 0,0,0,0,0,0};
      vecs[6]  = '{1,1,7,0,1, 1,7,1,1,1, 0,0,0, 0,0,0,1,1,1};
      vecs[7]  = '{1,5,9,1,1, 1,5,0,0,0, 1,5,1, 2,0,0,0,0,0};
      vecs[8]  = '{1,0,4,1,1, 0,0,0,0,0, 1,0,1, 0,0,0,0,0,0};
      vecs[9]  = '{1,7,0,1,0, 1,7,1,1,0, 1,7,1, 2,0,1,0,1,0};
      vecs[10] = '{1,5,6,1,1, 0,5,1,0,1, 0,0,0, 0,0,0,0,0,0};
      vecs[11] = '{0,7,2,1,1, 1,7,1,1,0, 0,0,0, 0,0,0,0,0,0};

      clear_inputs();
      rst = 0;
      @(negedge clk);

      // Reset for 3 cycles, then exactly two flush/bubble cycles.
      repeat (3) tick();
      rst = 1;
      #1;
      check("init1_flush", int'(flush_id), 1);
      check("init1_bubble", int'(bubble_ex), 1);
      check("init1_stall_if", int'(stall_if), 0);
      tick();
      #1;
      check("init2_flush", int'(flush_id), 1);
      check("init2_bubble", int'(bubble_ex), 1);
      tick();
      #1;
      check("run_flush", int'(flush_id), 0);
      check("run_bubble", int'(bubble_ex), 0);
      check("run_stall_if", int'(stall_if), 0);
      check("run_cycle_cnt", int'(cycle_cnt), 2);
      tick();

      foreach (vecs[i]) begin
         id_valid = 1'(vecs[i].idv); id_rs1 = 5'(vecs[i].rs1); id_rs2 = 5'(vecs[i].rs2);
         id_use_rs1 = 1'(vecs[i].u1); id_use_rs2 = 1'(vecs[i].u2);
         ex_valid = 1'(vecs[i].exv); ex_rd = 5'(vecs[i].exrd); ex_reg_wen = 1'(vecs[i].exwen);
         ex_is_load = 1'(vecs[i].exld); ex_redirect = 1'(vecs[i].exredir);
         wb_valid = 1'(vecs[i].wbv); wb_rd = 5'(vecs[i].wbrd); wb_reg_wen = 1'(vecs[i].wbwen);
         #1;
         check($sformatf("v%0d_fwd_a", i), int'(fwd_a_sel), vecs[i].fa);
         check($sformatf("v%0d_fwd_b", i), int'(fwd_b_sel), vecs[i].fb);
         check($sformatf("v%0d_stall_if", i), int'(stall_if), vecs[i].st);
         check($sformatf("v%0d_stall_id", i), int'(stall_id), vecs[i].st);
         check($sformatf("v%0d_flush", i), int'(flush_id), vecs[i].fl);
         check($sformatf("v%0d_bubble", i), int'(bubble_ex), vecs[i].bu);
         check($sformatf("v%0d_redirect", i), int'(pc_redirect_en), vecs[i].re);
         tick();
      end
      clear_inputs();

      // Memory wait: four not-ready cycles, then the ready cycle still stalls.
      mem_req = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("mw%0d_stall_if", k), int'(stall_if), 1);
         check($sformatf("mw%0d_stall_id", k), int'(stall_id), 1);
         check($sformatf("mw%0d_bubble", k), int'(bubble_ex), 0);
         tick();
      end
      mem_ready = 1;
      #1;
      check("mw_ready_stall_if", int'(stall_if), 1);
      tick();
      mem_req = 0; mem_ready = 0;
      #1;
      check("mw_after_stall_if", int'(stall_if), 0);
      check("mw_after_stall_id", int'(stall_id), 0);
      tick();

      // Redirect arriving during a memory wait is deferred to the first run cycle.
      mem_req = 1;
      tick();
      mem_req = 0; ex_valid = 1; ex_redirect = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("rdw%0d_redirect", k), int'(pc_redirect_en), 0);
         check($sformatf("rdw%0d_stall_if", k), int'(stall_if), 1);
         tick();
      end
      mem_ready = 1;
      #1;
      check("rdw_ready_redirect", int'(pc_redirect_en), 0);
      tick();
      mem_ready = 0;
      #1;
      check("rdw_run_redirect", int'(pc_redirect_en), 1);
      check("rdw_run_flush", int'(flush_id), 1);
      tick();
      clear_inputs();

      // instret wraps in a 4-bit counter; then reset lands mid memory wait.
      rst = 0;
      tick();
      rst = 1; wb_valid = 1;
      repeat (17) tick();
      wb_valid = 0;
      #1;
      check("instret_wrap", int'(instret_cnt), 1);
      mem_req = 1;
      tick();
      tick();
      rst = 0;
      #1;
      check("rst_mw_stall_if", int'(stall_if), 1);
      check("rst_mw_stall_id", int'(stall_id), 0);
      check("rst_mw_flush", int'(flush_id), 1);
      tick();
      rst = 1; mem_req = 0;
      #1;
      check("rst_mw_cycle_cnt", int'(cycle_cnt), 0);
      check("rst_mw_instret", int'(instret_cnt), 0);
      check("rst_mw_init_flush", int'(flush_id), 1);
      check("rst_mw_init_stall_if", int'(stall_if), 0);
      tick();

      for (int n = 0; n < 2000; n++) begin
         rst         = ($urandom_range(0, 99) != 0);
         id_valid    = 1'($urandom_range(0, 3) != 0);
         id_rs1      = 5'($urandom_range(0, 7));
         id_rs2      = 5'($urandom_range(0, 7));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         ex_valid    = 1'($urandom_range(0, 3) != 0);
         ex_rd       = 5'($urandom_range(0, 7));
         ex_reg_wen  = 1'($urandom_range(0, 1));
         ex_is_load  = 1'($urandom_range(0, 2) == 0);
         ex_redirect = 1'($urandom_range(0, 7) == 0);
         mem_req     = 1'($urandom_range(0, 5) == 0);
         mem_ready   = 1'($urandom_range(0, 1));
         wb_valid    = 1'($urandom_range(0, 1));
         wb_rd       = 5'($urandom_range(0, 7));
         wb_reg_wen  = 1'($urandom_range(0, 1));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
